// File: rtl/rsa_regbank_ctrl.sv
// Register bank, start/done control FSM and sticky status for the modexp core.
// Reads are combinational; writes and core handshakes take effect on the next cycle.
module rsa_regbank_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int REG_W    = 8,
  parameter int OP_BYTES = 2,
  localparam int OP_W    = OP_BYTES * REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_wdata,
  input  logic              reg_wr,
  output logic [REG_W-1:0]  reg_rdata,
  output logic [REG_W-1:0]  status_o,
  output logic              core_start,
  input  logic              core_done,
  input  logic [OP_W-1:0]   core_result,
  output logic [OP_W-1:0]   op_p,
  output logic [OP_W-1:0]   op_e,
  output logic [OP_W-1:0]   op_m,
  output logic [OP_W-1:0]   op_const,
  output logic              irq
);

  localparam int ADDR_STATUS = 0;
  localparam int ADDR_CTRL   = 1;
  localparam int OPR_BASE    = 2;
  localparam int OPR_NUM     = 4 * OP_BYTES;
  localparam int RES_BASE    = OPR_BASE + OPR_NUM;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q;
  logic             done_q;
  logic             err_q;
  logic             irq_en_q;
  logic             irq_q;
  logic             start_q;
  logic [REG_W-1:0] opr_q [OPR_NUM];
  logic [REG_W-1:0] res_q [OP_BYTES];

  int   addr_i;
  logic running;
  logic wr_status;
  logic wr_ctrl;
  logic wr_opr;
  logic start_req;
  logic start_ok;
  logic done_evt;
  logic err_evt;

  assign addr_i    = int'(reg_addr);
  assign running   = (state_q == ST_RUN);
  assign wr_status = reg_wr && (addr_i == ADDR_STATUS);
  assign wr_ctrl   = reg_wr && (addr_i == ADDR_CTRL);
  assign wr_opr    = reg_wr && (addr_i >= OPR_BASE) && (addr_i < RES_BASE);
  assign start_req = wr_ctrl && reg_wdata[0];
  assign start_ok  = start_req && !running;
  assign done_evt  = running && core_done;
  // Operand or restart writes while the core is busy are rejected and flagged.
  assign err_evt   = running && (wr_opr || start_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      start_q  <= 1'b0;
      for (int i = 0; i < OPR_NUM; i++) opr_q[i] <= '0;
      for (int i = 0; i < OP_BYTES; i++) res_q[i] <= '0;
    end else begin
      start_q <= start_ok;
      irq_q   <= (done_q | err_q) & irq_en_q;

      case (state_q)
        ST_IDLE: if (start_ok) state_q <= ST_RUN;
        ST_RUN:  if (core_done) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      if (wr_ctrl) irq_en_q <= reg_wdata[1];

      // Set beats a simultaneous write-one-to-clear.
      done_q <= done_evt | (done_q & ~(wr_status & reg_wdata[0]));
      err_q  <= err_evt  | (err_q  & ~(wr_status & reg_wdata[2]));

      for (int i = 0; i < OPR_NUM; i++)
        if (wr_opr && !running && (addr_i == OPR_BASE + i)) opr_q[i] <= reg_wdata;

      if (done_evt)
        for (int i = 0; i < OP_BYTES; i++) res_q[i] <= core_result[i*REG_W +: REG_W];
    end
  end

  always_comb begin
    status_o    = '0;
    status_o[0] = done_q;
    status_o[1] = running;
    status_o[2] = err_q;
  end

  always_comb begin
    reg_rdata = '0;
    if (addr_i == ADDR_STATUS) reg_rdata = status_o;
    if (addr_i == ADDR_CTRL)   reg_rdata[1] = irq_en_q;
    for (int i = 0; i < OPR_NUM; i++)
      if (addr_i == OPR_BASE + i) reg_rdata = opr_q[i];
    for (int i = 0; i < OP_BYTES; i++)
      if (addr_i == RES_BASE + i) reg_rdata = res_q[i];
  end

  for (genvar i = 0; i < OP_BYTES; i++) begin : g_op
    assign op_p[i*REG_W +: REG_W]     = opr_q[i];
    assign op_e[i*REG_W +: REG_W]     = opr_q[OP_BYTES + i];
    assign op_m[i*REG_W +: REG_W]     = opr_q[2*OP_BYTES + i];
    assign op_const[i*REG_W +: REG_W] = opr_q[3*OP_BYTES + i];
  end

  assign core_start = start_q;
  assign irq        = irq_q;

endmodule

// File: doc/rsa_regbank_ctrl.md
Name: rsa_regbank_ctrl

Overview:
- Parametrised register bank and control FSM for the modular-exponentiation datapath. It replaces the fixed 8-register, 8-bit scheme.
- Operands are multi-byte (OP_BYTES registers each). The block adds a start/done handshake to the core, a sticky done/error status, write protection while the core is busy, and an interrupt.
- Sits between the SPI register slave (address/data/valid interface) and the RSA core.

Parameters:
- ADDR_W, 4, register address width; 2**ADDR_W byte registers. Must satisfy 2+5*OP_BYTES <= 2**ADDR_W.
- REG_W, 8, register width in bits.
- OP_BYTES, 2, registers per operand. Operand width OP_W = OP_BYTES*REG_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- reg_addr  in  ADDR_W  register address from SPI slave
- reg_wdata  in  REG_W  write data
- reg_wr  in  1  write strobe, one cycle per write
- reg_rdata  out  REG_W  read data for reg_addr (combinational)
- status_o  out  REG_W  copy of STATUS register, for the SPI status byte
- core_start  out  1  one-cycle start pulse to the core
- core_done  in  1  one-cycle end-of-computation pulse from the core
- core_result  in  OP_W  core result, valid when core_done=1
- op_p, op_e, op_m, op_const  out  OP_W each  operand buses, held stable while busy
- irq  out  1  interrupt, level

Behaviour:
- Register map, little-endian bytes, OP_BYTES=k:
  - 0 STATUS: bit0 DONE (sticky, W1C), bit1 BUSY (read-only), bit2 ERR (sticky, W1C), other bits read 0.
  - 1 CTRL: bit0 START (write-only, reads 0), bit1 IRQ_EN (R/W), other bits read 0.
  - 2..2+k-1 P; then E, M, CONST, each k registers.
  - C (result, read-only) at 2+4k..2+5k-1.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset: all registers 0, FSM in IDLE, core_start=0, irq=0, status_o=0, all operand buses 0.
- Write timing: a write with reg_wr=1 at cycle N is visible on reg_rdata and the operand buses from cycle N+1.
- FSM has two states, IDLE and RUN.
  - IDLE: a CTRL write with bit0=1 moves the FSM to RUN. core_start=1 and BUSY=1 in cycle N+1 only for the pulse; BUSY stays 1 until done. DONE is not cleared by start.
  - RUN: the first core_done=1 captures core_result into the C registers and sets DONE. BUSY clears and the FSM returns to IDLE. C and DONE are visible in the next cycle.
  - core_done in IDLE is ignored: C is unchanged and DONE is not set.
- Protection in RUN:
  - Writes to P/E/M/CONST are dropped and set ERR.
  - A CTRL write with START=1 is dropped and sets ERR; its IRQ_EN bit still updates.
  - Writes to C are always dropped, with no ERR.
- W1C: writing 1 to STATUS bit0/bit2 clears DONE/ERR. If a clear and a set happen in the same cycle (core_done or an error event), the set wins.
- irq = (DONE | ERR) & IRQ_EN, registered, so it is one cycle behind the flags.
- status_o equals reg_rdata at address 0 at all times.
- Reset asserted mid-RUN: everything clears next cycle and the FSM goes to IDLE. The core shares rst, so any late core_done after reset is ignored because the FSM is in IDLE.
- A start and a core_done in the same cycle cannot occur, since start is only accepted in IDLE.

Test Plan (OP_BYTES=2: P=2..3, E=4..5, M=6..7, CONST=8..9, C=10..11):
- Reset then read every address 0..15 -> all 0x00; irq=0; core_start=0.
- Write P=0x34@2, 0x12@3 and E=0x05@4, 0x00@5 -> op_p=0x1234 and op_e=0x0005 on the cycle after each write.
- Write CTRL=0x03 -> core_start pulses for exactly 1 cycle, STATUS=0x02. Drive core_done with result 0xBEEF -> next cycle C reads 0xEF@10 / 0xBE@11, STATUS=0x01, irq=1 the following cycle.
- In RUN, write 0xFF to addr 2 and CTRL=0x01 -> op_p is unchanged, no second core_start, STATUS=0x06. Write STATUS=0x04 -> ERR clears, BUSY stays 1.
- DONE set, then write STATUS=0x01 in the same cycle as a core_done pulse while in RUN -> DONE remains 1. Separately, core_done in IDLE -> C and DONE are unchanged.
- Assert rst during RUN -> next cycle STATUS=0x00, operands 0. A core_done pulse afterwards has no effect.
